cpu_bus_responder_ram: RTL and testbench



---
 rtl/cpu_bus_responder_ram_pkg.sv | 24 ++
 rtl/cpu_bus_responder_ram_if.sv | 39 +++
 rtl/cpu_bus_responder_ram_ram.sv | 37 +++
 rtl/cpu_bus_responder_ram.sv | 161 ++++++++++++++++
 tb/tb_cpu_bus_responder_ram.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_responder_ram_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_pkg
// Shared types and constants for the CPU request/ready bus responder.
//   state_t        : responder FSM states
//   FAULT_PATTERN  : read data returned for out-of-range reads when the
//                    CPU_BUS_RESPONDER_FAULT_EN build option is defined
//   RW_READ/WRITE  : encoding of the i_rw bus signal
// ---------------------------------------------------------------------------
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESPOND,
        HOLD
    } state_t;

    localparam logic [31:0] FAULT_PATTERN = 32'hDEAD_BEEF;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/cpu_bus_responder_ram_if.sv
// ---------------------------------------------------------------------------
// cpu_bus_responder_ram_if
// CPU request/ready memory bus (level handshake).
//   i_request : initiator holds high for the whole transaction
//   i_rw      : 1 = write, 0 = read
//   i_address : byte address, bits [1:0] ignored by the responder
//   i_wdata   : write data
//   o_ready   : transaction complete, held until i_request drops
//   o_rdata   : read data, valid while o_ready=1 after a read
// Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface cpu_bus_responder_ram_if;

    logic        i_request;
    logic        i_rw;
    logic [31:0] i_address;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic [31:0] o_rdata;

    modport master (
        output i_request,
        output i_rw,
        output i_address,
        output i_wdata,
        input  o_ready,
        input  o_rdata
    );

    modport slave (
        input  i_request,
        input  i_rw,
        input  i_address,
        input  i_wdata,
        output o_ready,
        output o_rdata
    );

endinterface

// File: rtl/cpu_bus_responder_ram_ram.sv
// ---------------------------------------------------------------------------
// cpu_bus_ram_1rw
// Single-port synchronous RAM, 32-bit words, 2**ADDR_BITS deep.
// Registered read; on a write the written word appears on o_rdata
// (write-first). Contents are not reset.
//   i_clock   : clock, rising edge
//   i_enable  : access strobe for this cycle
//   i_write   : 1 = write, 0 = read (qualified by i_enable)
//   i_address : word index
//   i_wdata   : write data
//   o_rdata   : read data, valid the cycle after an enabled access
// ---------------------------------------------------------------------------
module cpu_bus_ram_1rw #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 i_clock,
    input  logic                 i_enable,
    input  logic                 i_write,
    input  logic [ADDR_BITS-1:0] i_address,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_rdata
);

    logic [31:0] mem [2**ADDR_BITS];

    always_ff @(posedge i_clock) begin
        if (i_enable) begin
            if (i_write) begin
                mem[i_address] <= i_wdata;
                o_rdata        <= i_wdata;
            end else begin
                o_rdata <= mem[i_address];
            end
        end
    end

endmodule

// File: rtl/cpu_bus_responder_ram.sv
// ---------------------------------------------------------------------------
// cpu_bus_responder_ram
// Bus responder for the CPU request/ready memory bus, fronting a
// word-addressed synchronous RAM with WAIT_STATES programmable idle cycles
// before each RAM access. o_ready is held until the initiator drops
// i_request.
//
// Parameters:
//   ADDR_BITS    : log2 of RAM depth in 32-bit words (at most 29)
//   WAIT_STATES  : idle cycles before the RAM access (0..255)
//   BASE_ADDRESS : byte address of RAM word 0
// Ports:
//   i_clock  : clock, rising edge
//   i_reset  : asynchronous active-high reset
//   bus      : cpu_bus_responder_ram_if.slave (request/rw/address/wdata in,
//              ready/rdata out)
//   o_fault  : only with CPU_BUS_RESPONDER_FAULT_EN defined; high together
//              with o_ready for an out-of-range transaction
//
// Build option CPU_BUS_RESPONDER_FAULT_EN: out-of-range accesses leave the
// RAM untouched, reads return FAULT_PATTERN and o_fault is raised. Without
// it, out-of-range addresses alias onto the RAM through the truncated index.
// ---------------------------------------------------------------------------
module cpu_bus_responder_ram
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 10,
    parameter int unsigned WAIT_STATES  = 2,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic i_clock,
    input  logic i_reset,
    cpu_bus_responder_ram_if.slave bus
`ifdef CPU_BUS_RESPONDER_FAULT_EN
    ,
    output logic o_fault
`endif
);

    state_t                 state;
    logic [7:0]             wait_count;
    logic                   lat_rw;
    logic [ADDR_BITS-1:0]   lat_index;
    logic [31:0]            lat_wdata;
    logic                   lat_oor;

    logic [31:0]            offset;
    logic [ADDR_BITS-1:0]   req_index;
    logic                   req_oor;

    logic                   ram_enable;
    logic                   ram_write;
    logic [31:0]            ram_rdata;

    // Address decode for the request currently on the bus.
    assign offset    = bus.i_address - BASE_ADDRESS;
    assign req_index = offset[ADDR_BITS+1:2];

`ifdef CPU_BUS_RESPONDER_FAULT_EN
    logic unused_offset_bits;
    assign req_oor            = |offset[31:ADDR_BITS+2];
    assign unused_offset_bits = ^offset[1:0];
`else
    logic unused_offset_bits;
    assign req_oor            = 1'b0;
    assign unused_offset_bits = ^{offset[1:0], offset[31:ADDR_BITS+2]};
`endif

    // RAM is touched only in ACCESS; a faulting access never reaches it.
    always_comb begin
        ram_enable = 1'b0;
        ram_write  = 1'b0;
        if (state == ACCESS && !lat_oor) begin
            ram_enable = 1'b1;
            ram_write  = (lat_rw == RW_WRITE);
        end
    end

    cpu_bus_ram_1rw #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .i_clock   (i_clock),
        .i_enable  (ram_enable),
        .i_write   (ram_write),
        .i_address (lat_index),
        .i_wdata   (lat_wdata),
        .o_rdata   (ram_rdata)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            wait_count  <= '0;
            lat_rw      <= RW_READ;
            lat_index   <= '0;
            lat_wdata   <= '0;
            lat_oor     <= 1'b0;
            bus.o_ready <= 1'b0;
            bus.o_rdata <= '0;
`ifdef CPU_BUS_RESPONDER_FAULT_EN
            o_fault     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_request) begin
                        lat_rw     <= bus.i_rw;
                        lat_index  <= req_index;
                        lat_wdata  <= bus.i_wdata;
                        lat_oor    <= req_oor;
                        wait_count <= 8'(WAIT_STATES);
                        state      <= (WAIT_STATES == 0) ? ACCESS : WAIT;
                    end
                end

                // Leaves after exactly WAIT_STATES cycles in this state.
                WAIT: begin
                    wait_count <= wait_count - 8'd1;
                    if (wait_count <= 8'd1) begin
                        state <= ACCESS;
                    end
                end

                ACCESS: begin
                    state <= RESPOND;
                end

                // Read data is captured even if the request was abandoned.
                RESPOND: begin
                    if (lat_rw == RW_READ) begin
                        bus.o_rdata <= lat_oor ? FAULT_PATTERN : ram_rdata;
                    end
                    if (bus.i_request) begin
                        bus.o_ready <= 1'b1;
`ifdef CPU_BUS_RESPONDER_FAULT_EN
                        o_fault     <= lat_oor;
`endif
                        state       <= HOLD;
                    end else begin
                        state <= IDLE;
                    end
                end

                HOLD: begin
                    if (!bus.i_request) begin
                        bus.o_ready <= 1'b0;
`ifdef CPU_BUS_RESPONDER_FAULT_EN
                        o_fault     <= 1'b0;
`endif
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder_ram.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_responder_ram
// Self-checking bench for cpu_bus_responder_ram. Two instances: one with
// WAIT_STATES=2 / BASE_ADDRESS=0, one with WAIT_STATES=0 / BASE_ADDRESS=0x1000.
// Honours CPU_BUS_RESPONDER_FAULT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_cpu_bus_responder_ram;
    import cpu_bus_pkg::*;

    localparam int unsigned AB    = 10;
    localparam int unsigned DEPTH = 1 << AB;
`ifdef CPU_BUS_RESPONDER_FAULT_EN
    localparam bit FAULT_ON = 1'b1;
`else
    localparam bit FAULT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    cpu_bus_responder_ram_if bus0 ();
    cpu_bus_responder_ram_if bus1 ();
`ifdef CPU_BUS_RESPONDER_FAULT_EN
    logic fault0, fault1;
`endif

    cpu_bus_responder_ram #(
        .ADDR_BITS    (AB),
        .WAIT_STATES  (2),
        .BASE_ADDRESS (32'h0000_0000)
    ) u_dut0 (
        .i_clock (clk),
        .i_reset (rst0),
        .bus     (bus0)
`ifdef CPU_BUS_RESPONDER_FAULT_EN
        ,
        .o_fault (fault0)
`endif
    );

    cpu_bus_responder_ram #(
        .ADDR_BITS    (AB),
        .WAIT_STATES  (0),
        .BASE_ADDRESS (32'h0000_1000)
    ) u_dut1 (
        .i_clock (clk),
        .i_reset (rst1),
        .bus     (bus1)
`ifdef CPU_BUS_RESPONDER_FAULT_EN
        ,
        .o_fault (fault1)
`endif
    );

    // Reference model: word array per instance plus the expected o_rdata.
    logic [31:0]  mem_m   [2][DEPTH];
    logic [31:0]  rdata_m [2];
    int unsigned  ws_m    [2];
    logic [31:0]  base_m  [2];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fill_val(input int unsigned i);
        return 32'h5A00_0000 ^ 32'(i * 32'h0001_0203);
    endfunction

    function automatic bit is_oor(input int d, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_m[d];
        return FAULT_ON && (off >= 32'(4 * DEPTH));
    endfunction

    function automatic int unsigned word_idx(input int d, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_m[d];
        return (off / 4) % DEPTH;
    endfunction

    task automatic model_access(input int d, input logic rw, input logic [31:0] a, input logic [31:0] w);
        if (is_oor(d, a)) begin
            if (rw == RW_READ) rdata_m[d] = FAULT_PATTERN;
        end else if (rw == RW_WRITE) begin
            mem_m[d][word_idx(d, a)] = w;
        end else begin
            rdata_m[d] = mem_m[d][word_idx(d, a)];
        end
    endtask

    task automatic set_req(input int d, input logic req, input logic rw,
                           input logic [31:0] a, input logic [31:0] w);
        if (d == 0) begin
            bus0.i_request = req; bus0.i_rw = rw; bus0.i_address = a; bus0.i_wdata = w;
        end else begin
            bus1.i_request = req; bus1.i_rw = rw; bus1.i_address = a; bus1.i_wdata = w;
        end
    endtask

    task automatic get_out(input int d, output logic rdy, output logic [31:0] rd, output logic flt);
        if (d == 0) begin
            rdy = bus0.o_ready; rd = bus0.o_rdata;
        end else begin
            rdy = bus1.o_ready; rd = bus1.o_rdata;
        end
`ifdef CPU_BUS_RESPONDER_FAULT_EN
        flt = (d == 0) ? fault0 : fault1;
`else
        flt = 1'b0;
`endif
    endtask

    // Full handshake: sample, wait for o_ready, hold, release.
    task automatic run_txn(input int d, input logic rw, input logic [31:0] a, input logic [31:0] w,
                           input int hold, input bit chg, output logic [31:0] got);
        logic        rdy, flt, exp_f;
        logic [31:0] rd;
        int          lat;
        set_req(d, 1'b1, rw, a, w);
        tick();
        exp_f = is_oor(d, a);
        model_access(d, rw, a, w);
        if (chg) set_req(d, 1'b1, ~rw, $urandom(), $urandom());
        get_out(d, rdy, rd, flt);
        lat = 0;
        while (!rdy && lat < 64) begin
            tick();
            lat++;
            get_out(d, rdy, rd, flt);
        end
        check("latency", 32'(lat), 32'(ws_m[d] + 2));
        check("rdata", rd, rdata_m[d]);
`ifdef CPU_BUS_RESPONDER_FAULT_EN
        check("fault", 32'(flt), 32'(exp_f));
`endif
        got = rd;
        for (int h = 0; h < hold; h++) begin
            tick();
            get_out(d, rdy, rd, flt);
            check("hold_ready", 32'(rdy), 32'd1);
            check("hold_rdata", rd, rdata_m[d]);
`ifdef CPU_BUS_RESPONDER_FAULT_EN
            check("hold_fault", 32'(flt), 32'(exp_f));
`endif
        end
        set_req(d, 1'b0, 1'($urandom()), $urandom(), $urandom());
        tick();
        get_out(d, rdy, rd, flt);
        check("release_ready", 32'(rdy), 32'd0);
        check("release_rdata", rd, rdata_m[d]);
`ifdef CPU_BUS_RESPONDER_FAULT_EN
        check("release_fault", 32'(flt), 32'd0);
`endif
    endtask

    // Request dropped after edge k (1 <= k <= WAIT_STATES+1): o_ready must never rise.
    task automatic abandon_txn(input int d, input logic rw, input logic [31:0] a,
                               input logic [31:0] w, input int k);
        logic        rdy, flt;
        logic [31:0] rd;
        int          highs;
        highs = 0;
        set_req(d, 1'b1, rw, a, w);
        tick();
        model_access(d, rw, a, w);
        for (int e = 1; e <= k; e++) begin
            tick();
            get_out(d, rdy, rd, flt);
            if (rdy) highs++;
        end
        set_req(d, 1'b0, rw, a, w);
        for (int e = k + 1; e <= int'(ws_m[d]) + 3; e++) begin
            tick();
            get_out(d, rdy, rd, flt);
            if (rdy) highs++;
        end
        check("abandon_noready", 32'(highs), 32'd0);
        check("abandon_rdata", rd, rdata_m[d]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        logic        rdy, flt;
        logic [31:0] rd;
        int          lat;

        ws_m[0] = 2;  base_m[0] = 32'h0000_0000;
        ws_m[1] = 0;  base_m[1] = 32'h0000_1000;
        rdata_m[0] = '0;
        rdata_m[1] = '0;

        // Directed vectors for instance 0 (WAIT_STATES=2, base 0).
        vt[0] = '{RW_WRITE, 32'h0000_0040, 32'h1234_5678, 0, 1'b0, 32'h0};
        vt[1] = '{RW_READ,  32'h0000_0040, 32'h0,         5, 1'b1, 32'h1234_5678};
        vt[2] = '{RW_READ,  32'h0000_0043, 32'h0,         1, 1'b1, 32'h1234_5678};
        vt[3] = '{RW_WRITE, 32'h0000_1004, 32'h1111_1111, 0, 1'b0, 32'h0};
`ifdef CPU_BUS_RESPONDER_FAULT_EN
        vt[4] = '{RW_READ,  32'h0000_1004, 32'h0,         0, 1'b1, 32'hDEAD_BEEF};
        vt[5] = '{RW_READ,  32'h0000_0004, 32'h0,         0, 1'b1, fill_val(1)};
`else
        vt[4] = '{RW_READ,  32'h0000_0004, 32'h0,         0, 1'b1, 32'h1111_1111};
        vt[5] = '{RW_READ,  32'h0000_1004, 32'h0,         0, 1'b1, 32'h1111_1111};
`endif
        vt[6] = '{RW_WRITE, 32'h0000_0FFC, 32'hFFFF_0000, 2, 1'b0, 32'h0};
        vt[7] = '{RW_READ,  32'h0000_0FFC, 32'h0,         0, 1'b1, 32'hFFFF_0000};

        // Reset state.
        rst0 = 1'b1;
        rst1 = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        #12;
        for (int d = 0; d < 2; d++) begin
            get_out(d, rdy, rd, flt);
            check("reset_ready", 32'(rdy), 32'd0);
            check("reset_rdata", rd, 32'd0);
`ifdef CPU_BUS_RESPONDER_FAULT_EN
            check("reset_fault", 32'(flt), 32'd0);
`endif
        end
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        tick();

        // Fill both RAMs with a known pattern.
        for (int d = 0; d < 2; d++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                run_txn(d, RW_WRITE, base_m[d] + 32'(4 * i), fill_val(i), 0, 1'b0, got);
            end
        end

        // Table-driven directed vectors.
        for (int i = 0; i < 8; i++) begin
            run_txn(0, vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].hold, 1'b0, got);
            if (vt[i].chk) check($sformatf("vec%0d", i), got, vt[i].exp);
        end

        // Abandoned write: dropped at edge 1, still committed.
        abandon_txn(0, RW_WRITE, 32'h0000_0080, 32'hA5A5_A5A5, 1);
        run_txn(0, RW_READ, 32'h0000_0080, '0, 0, 1'b0, got);
        check("abandon_commit", got, 32'hA5A5_A5A5);

        // Reset during WAIT of a write: not committed.
        run_txn(0, RW_WRITE, 32'h0000_0100, 32'h0, 0, 1'b0, got);
        set_req(0, 1'b1, RW_WRITE, 32'h0000_0100, 32'hFFFF_FFFF);
        tick();
        tick();
        rst0 = 1'b1;
        #1;
        get_out(0, rdy, rd, flt);
        check("rst_wait_ready", 32'(rdy), 32'd0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        rdata_m[0] = '0;
        tick();
        rst0 = 1'b0;
        tick();
        run_txn(0, RW_READ, 32'h0000_0100, '0, 0, 1'b0, got);
        check("rst_no_commit", got, 32'h0);

        // Asynchronous reset while o_ready is held.
        set_req(0, 1'b1, RW_READ, 32'h0000_0040, '0);
        tick();
        lat = 0;
        get_out(0, rdy, rd, flt);
        while (!rdy && lat < 64) begin
            tick();
            lat++;
            get_out(0, rdy, rd, flt);
        end
        check("pre_rst_ready", 32'(rdy), 32'd1);
        #2;
        rst0 = 1'b1;
        #1;
        get_out(0, rdy, rd, flt);
        check("async_rst_ready", 32'(rdy), 32'd0);
        check("async_rst_rdata", rd, 32'd0);
        rdata_m[0] = '0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        tick();
        rst0 = 1'b0;
        tick();

        // Zero wait states, inputs changed after sampling.
        run_txn(1, RW_WRITE, 32'h0000_1020, 32'hCAFE_F00D, 0, 1'b1, got);
        run_txn(1, RW_READ,  32'h0000_1020, '0, 1, 1'b1, got);
        check("ws0_latched_addr", got, 32'hCAFE_F00D);

        // Randomized traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            int          d;
            logic        rw;
            logic [31:0] a, w;
            d  = i % 2;
            rw = 1'($urandom());
            a  = 32'($urandom_range(0, 32'h3FFF));
            w  = $urandom();
            if ($urandom_range(0, 7) == 0) begin
                abandon_txn(d, rw, a, w, int'($urandom_range(1, ws_m[d] + 1)));
            end else begin
                run_txn(d, rw, a, w, int'($urandom_range(0, 3)), 1'($urandom()), got);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
